// File: rtl/program_sequencer.sv
// Program sequencer for the 4-bit microprocessor: program counter, next-address
// selection for jumps/branches, and a 4-deep hardware return stack.
module program_sequencer (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       jmp,
    input  logic       jmp_nz,
    input  logic       call,
    input  logic       ret,
    input  logic       hold,
    input  logic [7:0] jump_addr,
    input  logic       r_eq_0,
    output logic [7:0] pm_addr,
    output logic [7:0] pc,
    output logic [2:0] stack_depth,
    output logic       stack_err,
    output logic [7:0] from_PS
);

    localparam logic [2:0] STACK_FULL = 3'd4;

    logic [7:0] stack_mem [4];
    logic [7:0] pc_inc;
    logic [1:0] top_idx;
    logic       stack_empty;
    logic       stack_full;
    logic       do_push;
    logic       do_pop;
    logic       set_err;

    assign pc_inc      = pc + 8'd1;
    assign top_idx     = stack_depth[1:0] - 2'd1;
    assign stack_empty = (stack_depth == 3'd0);
    assign stack_full  = (stack_depth == STACK_FULL);
    assign from_PS     = pc;

    // Priority chain: a winning control masks every lower one, stack effects included.
    always_comb begin
        pm_addr = pc_inc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_err = 1'b0;
        if (sync_reset) begin
            pm_addr = 8'h00;
        end else if (hold) begin
            pm_addr = pc;
        end else if (ret) begin
            if (stack_empty) begin
                pm_addr = pc_inc;
                set_err = 1'b1;
            end else begin
                pm_addr = stack_mem[top_idx];
                do_pop  = 1'b1;
            end
        end else if (call) begin
            pm_addr = jump_addr;
            if (stack_full) begin
                set_err = 1'b1;
            end else begin
                do_push = 1'b1;
            end
        end else if (jmp) begin
            pm_addr = jump_addr;
        end else if (jmp_nz && !r_eq_0) begin
            pm_addr = jump_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc          <= 8'h00;
            stack_depth <= 3'd0;
            stack_err   <= 1'b0;
        end else begin
            pc <= pm_addr;
            if (do_push) begin
                stack_depth <= stack_depth + 3'd1;
            end else if (do_pop) begin
                stack_depth <= stack_depth - 3'd1;
            end
            if (set_err) begin
                stack_err <= 1'b1;
            end
        end
    end

    // Entries need no reset; depth alone decides which ones are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[stack_depth[1:0]] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with a scoreboard of
// expected post-edge state queued as each step is driven.
module tb_program_sequencer;

    logic       clk;
    logic       sync_reset;
    logic       jmp;
    logic       jmp_nz;
    logic       call;
    logic       ret;
    logic       hold;
    logic [7:0] jump_addr;
    logic       r_eq_0;
    logic [7:0] pm_addr;
    logic [7:0] pc;
    logic [2:0] stack_depth;
    logic       stack_err;
    logic [7:0] from_PS;

    typedef struct {
        string      tag;
        logic [7:0] pc;
        logic [2:0] depth;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    program_sequencer dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz),
        .call       (call),
        .ret        (ret),
        .hold       (hold),
        .jump_addr  (jump_addr),
        .r_eq_0     (r_eq_0),
        .pm_addr    (pm_addr),
        .pc         (pc),
        .stack_depth(stack_depth),
        .stack_err  (stack_err),
        .from_PS    (from_PS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h", tag, got, want);
            $error("[TB] %s differs", tag);
        end
    endtask

    // Drive one cycle of controls, check the combinational address, queue the post-edge state.
    task automatic applyStimulus(input string tag,
                                 input logic rst, input logic hld, input logic rt,
                                 input logic cl, input logic jp, input logic jnz,
                                 input logic [7:0] addr, input logic req0,
                                 input logic [7:0] exp_pm, input logic [2:0] exp_depth,
                                 input logic exp_err);
        exp_t e;
        sync_reset = rst;
        hold       = hld;
        ret        = rt;
        call       = cl;
        jmp        = jp;
        jmp_nz     = jnz;
        jump_addr  = addr;
        r_eq_0     = req0;
        #1;
        compare({tag, ".pm_addr"}, pm_addr, exp_pm);
        e.tag   = tag;
        e.pc    = exp_pm;
        e.depth = exp_depth;
        e.err   = exp_err;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue want pending entry");
        end else begin
            e = exp_q.pop_front();
            compare({e.tag, ".pc"}, pc, e.pc);
            compare({e.tag, ".from_PS"}, from_PS, e.pc);
            compare({e.tag, ".depth"}, {5'd0, stack_depth}, {5'd0, e.depth});
            compare({e.tag, ".err"}, {7'd0, stack_err}, {7'd0, e.err});
        end
    endtask

    task automatic step(input string tag,
                        input logic rst, input logic hld, input logic rt,
                        input logic cl, input logic jp, input logic jnz,
                        input logic [7:0] addr, input logic req0,
                        input logic [7:0] exp_pm, input logic [2:0] exp_depth,
                        input logic exp_err);
        applyStimulus(tag, rst, hld, rt, cl, jp, jnz, addr, req0, exp_pm, exp_depth, exp_err);
        checkOutput();
    endtask

    initial begin
        $display("[TB] program_sequencer bench start");
        //    tag                   rst hld ret cal jmp jnz addr   req0 pm     d     err
        step("reset0",              1,  0,  0,  0,  0,  0,  8'h00, 0,  8'h00, 3'd0, 0);
        step("reset1",              1,  0,  0,  0,  0,  0,  8'h00, 0,  8'h00, 3'd0, 0);
        for (int i = 0; i < 300; i++) begin
            step($sformatf("seq%0d", i), 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'((i + 1) % 256), 3'd0, 0);
        end

        // Conditional and unconditional jumps
        step("rst_jmp",             1,  0,  0,  0,  0,  0,  8'h00, 0,  8'h00, 3'd0, 0);
        for (int i = 0; i < 16; i++) begin
            step($sformatf("adv%0d", i), 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'(i + 1), 3'd0, 0);
        end
        step("jnz_not_taken",       0,  0,  0,  0,  0,  1,  8'h40, 1,  8'h11, 3'd0, 0);
        step("jnz_taken",           0,  0,  0,  0,  0,  1,  8'h40, 0,  8'h40, 3'd0, 0);
        step("jmp_req0_set",        0,  0,  0,  0,  1,  0,  8'h70, 1,  8'h70, 3'd0, 0);

        // Nested call/return
        step("rst_call",            1,  0,  0,  0,  0,  0,  8'h00, 0,  8'h00, 3'd0, 0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("to05_%0d", i), 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'(i + 1), 3'd0, 0);
        end
        step("call_20",             0,  0,  0,  1,  0,  0,  8'h20, 0,  8'h20, 3'd1, 0);
        step("idle_21",             0,  0,  0,  0,  0,  0,  8'h00, 0,  8'h21, 3'd1, 0);
        step("call_30",             0,  0,  0,  1,  0,  0,  8'h30, 0,  8'h30, 3'd2, 0);
        step("idle_31",             0,  0,  0,  0,  0,  0,  8'h00, 0,  8'h31, 3'd2, 0);
        step("call_50",             0,  0,  0,  1,  0,  0,  8'h50, 0,  8'h50, 3'd3, 0);
        step("ret_32",              0,  0,  1,  0,  0,  0,  8'h00, 0,  8'h32, 3'd2, 0);
        step("ret_22",              0,  0,  1,  0,  0,  0,  8'h00, 0,  8'h22, 3'd1, 0);
        step("ret_06",              0,  0,  1,  0,  0,  0,  8'h00, 0,  8'h06, 3'd0, 0);
        step("jmp_ff",              0,  0,  0,  0,  1,  0,  8'hFF, 0,  8'hFF, 3'd0, 0);
        step("call_at_ff",          0,  0,  0,  1,  0,  0,  8'h80, 0,  8'h80, 3'd1, 0);
        step("ret_wrap_00",         0,  0,  1,  0,  0,  0,  8'h00, 0,  8'h00, 3'd0, 0);

        // Overflow and underflow
        step("ovf_call1",           0,  0,  0,  1,  0,  0,  8'h10, 0,  8'h10, 3'd1, 0);
        step("ovf_call2",           0,  0,  0,  1,  0,  0,  8'h20, 0,  8'h20, 3'd2, 0);
        step("ovf_call3",           0,  0,  0,  1,  0,  0,  8'h30, 0,  8'h30, 3'd3, 0);
        step("ovf_call4",           0,  0,  0,  1,  0,  0,  8'h40, 0,  8'h40, 3'd4, 0);
        step("ovf_call5",           0,  0,  0,  1,  0,  0,  8'h50, 0,  8'h50, 3'd4, 1);
        step("ovf_ret_31",          0,  0,  1,  0,  0,  0,  8'h00, 0,  8'h31, 3'd3, 1);
        step("ovf_ret_21",          0,  0,  1,  0,  0,  0,  8'h00, 0,  8'h21, 3'd2, 1);
        step("ovf_ret_11",          0,  0,  1,  0,  0,  0,  8'h00, 0,  8'h11, 3'd1, 1);
        step("ovf_ret_01",          0,  0,  1,  0,  0,  0,  8'h00, 0,  8'h01, 3'd0, 1);
        step("udf_ret",             0,  0,  1,  0,  0,  0,  8'h00, 0,  8'h02, 3'd0, 1);
        step("err_clear",           1,  0,  0,  0,  0,  0,  8'h00, 0,  8'h00, 3'd0, 0);

        // Priority, hold, and reset overriding a call
        step("pri_idle",            0,  0,  0,  0,  0,  0,  8'h00, 0,  8'h01, 3'd0, 0);
        step("pri_call_60",         0,  0,  0,  1,  0,  0,  8'h60, 0,  8'h60, 3'd1, 0);
        step("pri_ret_call_jmp",    0,  0,  1,  1,  1,  0,  8'h90, 0,  8'h02, 3'd0, 0);
        step("call_08",             0,  0,  0,  1,  0,  0,  8'h08, 0,  8'h08, 3'd1, 0);
        step("hold_call",           0,  1,  0,  1,  0,  0,  8'h90, 0,  8'h08, 3'd1, 0);
        step("hold_ret",            0,  1,  1,  0,  0,  0,  8'h00, 0,  8'h08, 3'd1, 0);
        step("hold_jnz",            0,  1,  0,  0,  0,  1,  8'h90, 0,  8'h08, 3'd1, 0);
        step("call_a0",             0,  0,  0,  1,  0,  0,  8'hA0, 0,  8'hA0, 3'd2, 0);
        step("rst_over_call",       1,  0,  0,  1,  0,  0,  8'hB0, 0,  8'h00, 3'd0, 0);
        step("post_rst_ret",        0,  0,  1,  0,  0,  0,  8'h00, 0,  8'h01, 3'd0, 1);
        step("call_over_jnz",       0,  0,  0,  1,  0,  1,  8'hC0, 0,  8'hC0, 3'd1, 1);
        step("ret_from_c0",         0,  0,  1,  0,  0,  0,  8'h00, 0,  8'h02, 3'd0, 1);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
